bcd_serial_add_ctrl: RTL

//  Digit-serial sequencer for one shared single-digit BCD adder (external).

---
 rtl/bcd_serial_add_if.sv | 42 ++++
 rtl/bcd_serial_add_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_if.sv
// Bus between the system control path, the shared BCD digit adder and bcd_serial_add_ctrl.
// Optional macro BCD_SUB_EN adds the `sub` request qualifier.
interface bcd_serial_add_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  c_in;
`ifdef BCD_SUB_EN
  logic                  sub;
`endif
  logic [3:0]            dig_x;
  logic [3:0]            dig_y;
  logic                  dig_cin;
  logic [3:0]            dig_z;
  logic                  dig_cout;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  c_out;

`ifdef BCD_SUB_EN
  modport master (
    output start, a, b, c_in, sub, dig_z, dig_cout,
    input  dig_x, dig_y, dig_cin, busy, done, sum, c_out
  );
  modport slave (
    input  start, a, b, c_in, sub, dig_z, dig_cout,
    output dig_x, dig_y, dig_cin, busy, done, sum, c_out
  );
`else
  modport master (
    output start, a, b, c_in, dig_z, dig_cout,
    input  dig_x, dig_y, dig_cin, busy, done, sum, c_out
  );
  modport slave (
    input  start, a, b, c_in, dig_z, dig_cout,
    output dig_x, dig_y, dig_cin, busy, done, sum, c_out
  );
`endif
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial sequencer feeding one shared BCD digit adder, LSD first.
// Optional macro BCD_SUB_EN: latched `sub` selects 10s-complement subtraction.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input logic             clk,
  input logic             rst,
  bcd_serial_add_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             c_out_r;
  logic             busy_r;
  logic             done_r;
  logic             carry_init_s;
  logic [3:0]       dig_y_s;
`ifdef BCD_SUB_EN
  logic             sub_r;
`endif

  // Adder operand select; subtraction feeds the 9s complement with a forced carry-in.
  always_comb begin
    dig_y_s      = b_r[3:0];
    carry_init_s = bus.c_in;
`ifdef BCD_SUB_EN
    if (sub_r) begin
      dig_y_s = 4'd9 - b_r[3:0];
    end else begin
      dig_y_s = b_r[3:0];
    end
    if (bus.sub) begin
      carry_init_s = 1'b1;
    end else begin
      carry_init_s = bus.c_in;
    end
`endif
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register; busy/done registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Operand capture, digit shifting, carry ripple and result collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
`ifdef BCD_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= carry_init_s;
            cnt_r   <= {CNT_W{1'b0}};
`ifdef BCD_SUB_EN
            sub_r   <= bus.sub;
`endif
          end
        end
        RUN: begin
          sum_r   <= {bus.dig_z, sum_r[W-1:4]};
          carry_r <= bus.dig_cout;
          a_r     <= {4'd0, a_r[W-1:4]};
          b_r     <= {4'd0, b_r[W-1:4]};
          // Counter parks on the last digit instead of wrapping.
          if (cnt_r == CNT_LAST) begin
            c_out_r <= bus.dig_cout;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.dig_x   = a_r[3:0];
  assign bus.dig_y   = dig_y_s;
  assign bus.dig_cin = carry_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.sum     = sum_r;
  assign bus.c_out   = c_out_r;
endmodule
